particle_raster: RTL and testbench

//  Downstream of the per-particle physics stage. On each frame_tick, samples the
//  NUM_PART particle positions (signed fixed point, FRAC_BITS fractional bits),

---
 rtl/particle_raster_if.sv | 25 ++
 rtl/particle_raster.sv | 87 ++++++++
 tb/tb_particle_raster.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/particle_raster_if.sv
// particle_raster_if: frame sampling inputs plus the row scan-out handshake
interface particle_raster_if #(
  parameter int NUM_PART = 3,
  parameter int COORD_W = 32
);
  logic frame_tick;
  logic [NUM_PART*COORD_W-1:0] px_flat;
  logic [NUM_PART*COORD_W-1:0] py_flat;
  logic row_valid;
  logic row_ready;
  logic [3:0] row_idx;
  logic [15:0] row_data;
  logic busy;
  logic frame_done;
  logic [7:0] clip_cnt;
  logic overrun;
  modport slave (
    input frame_tick, px_flat, py_flat, row_ready,
    output row_valid, row_idx, row_data, busy, frame_done, clip_cnt, overrun
  );
  modport master (
    output frame_tick, px_flat, py_flat, row_ready,
    input row_valid, row_idx, row_data, busy, frame_done, clip_cnt, overrun
  );
endinterface

// File: rtl/particle_raster.sv
// particle_raster: plots sampled particle positions into a double-buffered 16x16 bitmap
module particle_raster #(
  parameter int NUM_PART = 3,
  parameter int FRAC_BITS = 4,
  parameter int COORD_W = 32
) (
  input logic clk,
  input logic reset,
  particle_raster_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, PLOT, SWAP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, row_idx;
  logic [NUM_PART*COORD_W-1:0] lx, ly;
  logic [15:0] mem [2][16];
  logic sel, row_valid, boundary, last;
  logic [4:0] cx, cy;
  logic [8:0] clip_sum;
  logic [7:0] clip_cnt;
  logic overrun;

  function automatic logic [4:0] to_cell(input logic [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] s;
    s = $signed(c) >>> FRAC_BITS;
    return s < 0 ? 5'h10 : s > 15 ? 5'h1f : {1'b0, s[3:0]};
  endfunction

  // bit 4 of each cell flags a clamp on that axis
  assign cx = to_cell(lx[COORD_W-1:0]);
  assign cy = to_cell(ly[COORD_W-1:0]);
  assign clip_sum = {1'b0, clip_cnt} + {8'd0, cx[4]} + {8'd0, cy[4]};
  assign boundary = row_valid && bus.row_ready && row_idx == 4'd15;
  assign last = state == CLEAR ? cnt == 4'd15 : cnt == 4'(NUM_PART - 1);

  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_nx;

  always_comb begin
    state_nx = state == IDLE  ? (bus.frame_tick ? CLEAR : IDLE)
             : state == CLEAR ? (last ? PLOT : CLEAR)
             : state == PLOT  ? (last ? SWAP : PLOT)
             : (boundary ? IDLE : SWAP);
  end

  always_comb begin
    bus.busy = state != IDLE;
    bus.frame_done = state == SWAP && boundary;
  end

  // latched coordinates shift down one particle per PLOT cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      row_idx <= '0;
      row_valid <= 1'b0;
      sel <= 1'b0;
      clip_cnt <= '0;
      overrun <= 1'b0;
      lx <= '0;
      ly <= '0;
      mem <= '{default: '0};
    end else begin
      row_valid <= 1'b1;
      if (row_valid && bus.row_ready) row_idx <= row_idx + 4'd1;
      if (bus.frame_tick && state != IDLE) overrun <= 1'b1;
      cnt <= state != state_nx ? 4'd0 : cnt + 4'd1;
      if (state == IDLE && bus.frame_tick) begin
        lx <= bus.px_flat;
        ly <= bus.py_flat;
      end
      if (state == CLEAR) mem[~sel][cnt] <= '0;
      if (state == PLOT) begin
        mem[~sel][~cy[3:0]][cx[3:0]] <= 1'b1;
        lx <= lx >> COORD_W;
        ly <= ly >> COORD_W;
        clip_cnt <= clip_sum[8] ? 8'hff : clip_sum[7:0];
      end
      if (state == SWAP && boundary) sel <= ~sel;
    end
  end

  assign bus.row_valid = row_valid;
  assign bus.row_idx = row_idx;
  assign bus.row_data = mem[sel][row_idx];
  assign bus.clip_cnt = clip_cnt;
  assign bus.overrun = overrun;
endmodule

// File: tb/tb_particle_raster.sv
// tb_particle_raster: scoreboard bench with a frame-level reference model of the raster
module tb_particle_raster;
  localparam int NP = 3, CW = 32;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  particle_raster_if #(.NUM_PART(NP), .COORD_W(CW)) bus ();
  particle_raster #(.NUM_PART(NP), .FRAC_BITS(4), .COORD_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [3:0] idx;
    logic [15:0] data;
    logic done;
    logic busy;
    logic ovr;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  logic [15:0] m_front [16];
  logic [15:0] m_pend [16];
  int m_idx = 0, cd = 0, m_clip = 0;
  bit m_valid = 0, m_busy = 0, m_ovr = 0;

  function automatic int floor16(int p);
    return p < 0 ? -((-p + 15) / 16) : p / 16;
  endfunction

  // model: at each negedge predict this cycle's handshake, then advance to the next edge
  always @(negedge clk) begin
    bit hs, done;
    int x, y;
    hs = m_valid && bus.row_ready;
    done = m_busy && cd == 0 && hs && m_idx == 15;
    if (hs) q.push_back({4'(m_idx), m_front[m_idx], done, m_busy, m_ovr});
    if (!reset) begin
      m_front = '{default: 16'h0};
      m_idx = 0; m_valid = 0; m_busy = 0; m_ovr = 0; m_clip = 0; cd = 0;
    end else begin
      if (m_busy) begin
        if (bus.frame_tick) m_ovr = 1;
        if (cd > 0) cd--;
        else if (done) begin
          m_front = m_pend;
          m_busy = 0;
        end
      end else if (bus.frame_tick) begin
        m_pend = '{default: 16'h0};
        for (int k = 0; k < NP; k++) begin
          x = floor16($signed(bus.px_flat[k*CW +: CW]));
          y = floor16($signed(bus.py_flat[k*CW +: CW]));
          if (x < 0 || x > 15) m_clip = m_clip < 255 ? m_clip + 1 : 255;
          if (y < 0 || y > 15) m_clip = m_clip < 255 ? m_clip + 1 : 255;
          x = x < 0 ? 0 : x > 15 ? 15 : x;
          y = y < 0 ? 0 : y > 15 ? 15 : y;
          m_pend[15 - y] = m_pend[15 - y] | (16'h1 << x);
        end
        m_busy = 1;
        cd = 1 + 16 + NP - 1;
      end
      if (hs) m_idx = (m_idx + 1) % 16;
      m_valid = 1;
    end
  end

  always @(negedge clk) begin
    exp_t e, a;
    #1;
    if (bus.row_valid && bus.row_ready) begin
      checks++;
      a = {bus.row_idx, bus.row_data, bus.frame_done, bus.busy, bus.overrun};
      if (q.size() == 0) begin
        failures++;
        $display("FAIL scan: unexpected handshake idx=%0d data=%h", bus.row_idx, bus.row_data);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL scan: got idx=%0d data=%h done=%b busy=%b ovr=%b want idx=%0d data=%h done=%b busy=%b ovr=%b",
                   a.idx, a.data, a.done, a.busy, a.ovr, e.idx, e.data, e.done, e.busy, e.ovr);
        end
      end
    end else if (bus.frame_done) begin
      checks++;
      failures++;
      $display("FAIL stray_done: frame_done=1 without a handshake, want 0");
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic put(int k, int cx, int cy);
    bus.px_flat[k*CW +: CW] = cx * 16 + int'($urandom_range(0, 15));
    bus.py_flat[k*CW +: CW] = cy * 16 + int'($urandom_range(0, 15));
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      #1;
      got = bus.frame_done;
    end
    chk(name, 32'(got), 1);
    step();
  endtask

  task automatic check_row(int r, logic [15:0] want, string name);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = bus.row_valid && bus.row_idx == 4'(r);
    end
    chk(name, hit ? 32'(bus.row_data) : 32'hdead_beef, 32'(want));
    step();
  endtask

  initial begin
    logic [15:0] held;
    bit found;
    bus.frame_tick = 1'b0;
    bus.row_ready = 1'b0;
    bus.px_flat = '0;
    bus.py_flat = '0;
    step(3);
    chk("reset_state", {bus.row_valid, bus.busy, bus.frame_done, bus.overrun, bus.clip_cnt, bus.row_idx, bus.row_data}, 0);
    reset = 1'b1;
    bus.row_ready = 1'b1;
    step();
    chk("valid_rise", 32'(bus.row_valid), 1);
    // T1: empty frames stream and wrap
    check_row(15, 16'h0, "t1_row15");
    chk("t1_wrap", 32'(bus.row_idx), 0);
    step(20);
    // T2: three particles in range
    put(0, 2, 3); put(1, 15, 0); put(2, 7, 15);
    tick();
    bus.px_flat = '1;
    wait_done("t2_done", 80);
    check_row(12, 16'h0004, "t2_row12");
    check_row(15, 16'h8000, "t2_row15");
    check_row(0, 16'h0080, "t2_row0");
    chk("t2_clip", 32'(bus.clip_cnt), 0);
    // T3: both axes of particle 0 clamp
    bus.px_flat[0 +: CW] = -5;
    bus.py_flat[0 +: CW] = 32'h400;
    put(1, 5, 5); put(2, 9, 9);
    tick();
    wait_done("t3_done", 80);
    check_row(0, 16'h0001, "t3_row0");
    chk("t3_clip", 32'(bus.clip_cnt), 2);
    // T4: coincident particles share one bit
    put(0, 4, 4); put(1, 4, 4); put(2, 10, 2);
    tick();
    wait_done("t4_done", 80);
    check_row(11, 16'h0010, "t4_row11");
    check_row(13, 16'h0400, "t4_row13");
    // T5: stall scan-out at row 6 across the swap wait
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.row_idx == 4'd6) begin
        bus.row_ready = 1'b0;
        found = 1;
      end else step();
    end
    chk("t5_reach6", 32'(found), 1);
    held = bus.row_data;
    put(0, 3, 15); put(1, 1, 1); put(2, 2, 2);
    tick();
    step(40);
    chk("t5_hold", {bus.busy, bus.row_idx, bus.row_data}, {1'b1, 4'd6, held});
    bus.row_ready = 1'b1;
    wait_done("t5_done", 12);
    check_row(0, 16'h0008, "t5_row0");
    // T6: overrun during PLOT, then reset during CLEAR
    put(0, 6, 8); put(1, 0, 0); put(2, 12, 12);
    tick();
    step(17);
    tick();
    chk("t6_overrun", 32'(bus.overrun), 1);
    wait_done("t6_done", 80);
    check_row(3, 16'h1000, "t6_row3");
    check_row(7, 16'h0040, "t6_row7");
    put(0, 9, 9); put(1, 1, 14); put(2, 14, 1);
    tick();
    step(5);
    chk("t6_busy_clear", 32'(bus.busy), 1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step();
    chk("t6_after_reset", {bus.busy, bus.overrun, bus.clip_cnt}, 0);
    step(40);
    check_row(6, 16'h0, "t6_row6_zero");
    // randomized frames with random back-pressure and stray ticks
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < NP; k++) begin
        bus.px_flat[k*CW +: CW] = $urandom_range(0, 384) - 64;
        bus.py_flat[k*CW +: CW] = $urandom_range(0, 384) - 64;
      end
      tick();
      for (int i = 0; i < 120; i++) begin
        bus.row_ready = ($urandom % 4) != 0;
        bus.frame_tick = ($urandom % 50) == 0;
        step();
      end
      bus.frame_tick = 1'b0;
      bus.row_ready = 1'b1;
      for (int i = 0; i < 60 && bus.busy; i++) step();
      chk("rand_idle", 32'(bus.busy), 0);
      chk("rand_clip", 32'(bus.clip_cnt), 32'(m_clip));
      chk("rand_overrun", 32'(bus.overrun), 32'(m_ovr));
    end
    step(20);
    chk("queue_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
